// File: rtl/axis_write_sched_if.sv
// ---------------------------------------------------------------------------
// axis_write_sched_if : requester, config and stream-monitor signals of the scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface axis_write_sched_if #(
  parameter int NUM_REQ       = 2,
  parameter int CONFIG_AWIDTH = 5,
  parameter int CONFIG_DWIDTH = 32
);
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_addr;
  logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]               grant;
  logic [NUM_REQ-1:0]               done;
  logic                             busy;
  logic [CONFIG_AWIDTH-1:0]         cfg_addr;
  logic [CONFIG_DWIDTH-1:0]         cfg_data;
  logic                             cfg_valid;
  logic                             mon_valid;
  logic                             mon_ready;

  modport master (
    input  req, req_addr, req_len, mon_valid, mon_ready,
    output grant, done, busy, cfg_addr, cfg_data, cfg_valid
  );

  modport slave (
    output req, req_addr, req_len, mon_valid, mon_ready,
    input  grant, done, busy, cfg_addr, cfg_data, cfg_valid
  );
endinterface

`default_nettype wire

// File: rtl/axis_write_sched.sv
// ---------------------------------------------------------------------------
// axis_write_sched : round-robin sharing of one axis_write engine among NUM_REQ producers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_write_sched #(
  parameter int NUM_REQ        = 2,
  parameter int CONFIG_ID_BASE = 1,
  parameter int CONFIG_ADDR    = 23,
  parameter int CONFIG_DATA    = 24,
  parameter int CONFIG_AWIDTH  = 5,
  parameter int CONFIG_DWIDTH  = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  axis_write_sched_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CFG_ID   = 3'd1;
  localparam logic [2:0] S_CFG_ADDR = 3'd2;
  localparam logic [2:0] S_CFG_LEN  = 3'd3;
  localparam logic [2:0] S_STREAM   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]               state, state_nxt;
  logic [IW-1:0]            ptr, sel;
  logic [CONFIG_DWIDTH-1:0] sel_addr, sel_len, lat_addr, lat_len, cnt;
  logic                     hs, last_word;

  logic [NUM_REQ-1:0]       grant_reg, grant_nxt, done_reg, done_nxt;
  logic                     busy_reg, busy_nxt, cfg_valid_reg, cfg_valid_nxt;
  logic [CONFIG_AWIDTH-1:0] cfg_addr_reg, cfg_addr_nxt;
  logic [CONFIG_DWIDTH-1:0] cfg_data_reg, cfg_data_nxt;

  // Lowest set request overall, overridden by the lowest set request above ptr.
  always_comb begin
    sel      = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) sel = IW'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (i > int'(ptr))) sel = IW'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_addr = bus.req_addr[i*CONFIG_DWIDTH +: CONFIG_DWIDTH];
        sel_len  = bus.req_len[i*CONFIG_DWIDTH +: CONFIG_DWIDTH];
      end
    end
  end

  assign hs        = bus.mon_valid & bus.mon_ready;
  assign last_word = hs && (cnt == (lat_len - CONFIG_DWIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A zero-length grant parks in DONE for one extra cycle before the done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (|bus.req) state_nxt = (sel_len == '0) ? S_DONE : S_CFG_ID;
      S_CFG_ID:   state_nxt = S_CFG_ADDR;
      S_CFG_ADDR: state_nxt = S_CFG_LEN;
      S_CFG_LEN:  state_nxt = S_STREAM;
      S_STREAM:   if (last_word) state_nxt = S_DONE;
      S_DONE:     if (|done_reg) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so that they are registered.
  always_comb begin
    grant_nxt     = grant_reg;
    done_nxt      = '0;
    busy_nxt      = (state_nxt != S_IDLE);
    cfg_valid_nxt = 1'b0;
    cfg_addr_nxt  = '0;
    cfg_data_nxt  = '0;
    if (state_nxt == S_IDLE)    grant_nxt = '0;
    else if (state == S_IDLE)   grant_nxt = NUM_REQ'(1) << sel;
    if ((state_nxt == S_DONE) && (state != S_IDLE)) done_nxt = grant_reg;
    case (state_nxt)
      S_CFG_ID: begin
        cfg_valid_nxt = 1'b1;
        cfg_addr_nxt  = CONFIG_AWIDTH'(CONFIG_ADDR);
        cfg_data_nxt  = CONFIG_DWIDTH'(CONFIG_ID_BASE) + CONFIG_DWIDTH'(sel);
      end
      S_CFG_ADDR: begin
        cfg_valid_nxt = 1'b1;
        cfg_addr_nxt  = CONFIG_AWIDTH'(CONFIG_DATA);
        cfg_data_nxt  = lat_addr;
      end
      S_CFG_LEN: begin
        cfg_valid_nxt = 1'b1;
        cfg_addr_nxt  = CONFIG_AWIDTH'(CONFIG_DATA);
        cfg_data_nxt  = lat_len;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= IW'(NUM_REQ - 1);
      lat_addr      <= '0;
      lat_len       <= '0;
      cnt           <= '0;
      grant_reg     <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
      cfg_valid_reg <= 1'b0;
      cfg_addr_reg  <= '0;
      cfg_data_reg  <= '0;
    end else begin
      grant_reg     <= grant_nxt;
      done_reg      <= done_nxt;
      busy_reg      <= busy_nxt;
      cfg_valid_reg <= cfg_valid_nxt;
      cfg_addr_reg  <= cfg_addr_nxt;
      cfg_data_reg  <= cfg_data_nxt;
      if ((state == S_IDLE) && (|bus.req)) begin
        ptr      <= sel;
        lat_addr <= sel_addr;
        lat_len  <= sel_len;
      end
      if (state != S_STREAM) cnt <= '0;
      else if (hs)           cnt <= last_word ? '0 : cnt + CONFIG_DWIDTH'(1);
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.done      = done_reg;
  assign bus.busy      = busy_reg;
  assign bus.cfg_valid = cfg_valid_reg;
  assign bus.cfg_addr  = cfg_addr_reg;
  assign bus.cfg_data  = cfg_data_reg;

endmodule

`default_nettype wire

// File: tb/tb_axis_write_sched.sv
// ---------------------------------------------------------------------------
// tb_axis_write_sched : directed vector bench for axis_write_sched
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axis_write_sched;

  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int CA      = 23;
  localparam int CD      = 24;
  localparam int IDB     = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_write_sched_if #(.NUM_REQ(NUM_REQ), .CONFIG_AWIDTH(AW), .CONFIG_DWIDTH(DW)) bus ();

  axis_write_sched #(
    .NUM_REQ(NUM_REQ), .CONFIG_ID_BASE(IDB), .CONFIG_ADDR(CA),
    .CONFIG_DATA(CD), .CONFIG_AWIDTH(AW), .CONFIG_DWIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  req_set;
    logic [31:0] a0;
    logic [31:0] l0;
    logic [31:0] a1;
    logic [31:0] l1;
    int          who;
    int          mode;
    bit          drop;
    logic [1:0]  raise;
  } vec_t;

  vec_t tbl[9];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request must already be driven; grant is expected on the next edge.
  task automatic txn(input int who, input logic [31:0] addr, input int len,
                     input int mode, input bit drop, input logic [1:0] raise);
    logic [1:0] oh;
    int hs, c;
    bit v, r;
    oh = 2'b01 << who;
    step();
    check("grant", 64'(bus.grant), 64'(oh));
    check("busy", 64'(bus.busy), 64'd1);
    check("cfg_id_valid", 64'(bus.cfg_valid), 64'd1);
    check("cfg_id_addr", 64'(bus.cfg_addr), 64'(CA));
    check("cfg_id_data", 64'(bus.cfg_data), 64'(IDB + who));
    step();
    check("cfg_addr_valid", 64'(bus.cfg_valid), 64'd1);
    check("cfg_addr_addr", 64'(bus.cfg_addr), 64'(CD));
    check("cfg_addr_data", 64'(bus.cfg_data), 64'(addr));
    step();
    check("cfg_len_valid", 64'(bus.cfg_valid), 64'd1);
    check("cfg_len_addr", 64'(bus.cfg_addr), 64'(CD));
    check("cfg_len_data", 64'(bus.cfg_data), 64'(len));
    check("done_in_cfg", 64'(bus.done), 64'd0);
    step();
    check("cfg_end_valid", 64'(bus.cfg_valid), 64'd0);
    check("cfg_end_data", 64'(bus.cfg_data), 64'd0);
    check("done_before_stream", 64'(bus.done), 64'd0);
    if (raise != 2'b00) bus.req = bus.req | raise;
    hs = 0;
    c  = 0;
    while (hs < len) begin
      v = (mode == 0) ? 1'b1 : ((c % 3) != 2);
      r = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      bus.mon_valid = v;
      bus.mon_ready = r;
      step();
      c++;
      if (v && r) hs++;
      if (hs < len) check("done_early", 64'(bus.done), 64'd0);
      check("stream_cfg_quiet", 64'(bus.cfg_valid), 64'd0);
    end
    check("done", 64'(bus.done), 64'(oh));
    check("grant_in_done", 64'(bus.grant), 64'(oh));
    check("busy_in_done", 64'(bus.busy), 64'd1);
    bus.mon_valid = 1'b0;
    bus.mon_ready = 1'b0;
    if (drop) bus.req = bus.req & ~oh;
    step();
    check("busy_after", 64'(bus.busy), 64'd0);
    check("grant_after", 64'(bus.grant), 64'd0);
    check("done_after", 64'(bus.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            req    a0            l0     a1            l1     who mode drop raise
    tbl[0] = '{2'b11, 32'h0000_0100, 32'd3, 32'h0000_0200, 32'd3, 0, 0, 1'b0, 2'b00};
    tbl[1] = '{2'b11, 32'h0000_0100, 32'd3, 32'h0000_0200, 32'd3, 1, 0, 1'b0, 2'b00};
    tbl[2] = '{2'b11, 32'h0000_0100, 32'd3, 32'h0000_0200, 32'd3, 0, 0, 1'b1, 2'b00};
    tbl[3] = '{2'b00, 32'h0000_0100, 32'd3, 32'h0000_0200, 32'd3, 1, 0, 1'b1, 2'b00};
    tbl[4] = '{2'b01, 32'h0000_0004, 32'd8, 32'h0000_0000, 32'd1, 0, 0, 1'b1, 2'b00};
    tbl[5] = '{2'b01, 32'hDEAD_BEE0, 32'd5, 32'h0000_0000, 32'd1, 0, 1, 1'b1, 2'b00};
    tbl[6] = '{2'b10, 32'h0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 0, 1'b1, 2'b00};
    tbl[7] = '{2'b01, 32'h0000_0030, 32'd3, 32'h0000_0077, 32'd2, 0, 0, 1'b1, 2'b10};
    tbl[8] = '{2'b00, 32'h0000_0030, 32'd3, 32'h0000_0077, 32'd2, 1, 0, 1'b1, 2'b00};

    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.mon_valid = 1'b0;
    bus.mon_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cfg_valid", 64'(bus.cfg_valid), 64'd0);
    check("rst_cfg_addr", 64'(bus.cfg_addr), 64'd0);
    check("rst_cfg_data", 64'(bus.cfg_data), 64'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 64'(bus.busy), 64'd0);

    for (int k = 0; k < 9; k++) begin
      bus.req      = bus.req | tbl[k].req_set;
      bus.req_addr = {tbl[k].a1, tbl[k].a0};
      bus.req_len  = {tbl[k].l1, tbl[k].l0};
      txn(tbl[k].who,
          (tbl[k].who == 1) ? tbl[k].a1 : tbl[k].a0,
          int'((tbl[k].who == 1) ? tbl[k].l1 : tbl[k].l0),
          tbl[k].mode, tbl[k].drop, tbl[k].raise);
    end

    // Zero-length request from requester 1: no config words, done two cycles later.
    bus.req      = 2'b10;
    bus.req_addr = {32'h0000_0050, 32'h0};
    bus.req_len  = {32'd0, 32'd0};
    step();
    check("z_grant", 64'(bus.grant), 64'd2);
    check("z_busy", 64'(bus.busy), 64'd1);
    check("z_cfg_valid1", 64'(bus.cfg_valid), 64'd0);
    check("z_done1", 64'(bus.done), 64'd0);
    step();
    check("z_done2", 64'(bus.done), 64'd2);
    check("z_cfg_valid2", 64'(bus.cfg_valid), 64'd0);
    check("z_cfg_data2", 64'(bus.cfg_data), 64'd0);
    bus.req = 2'b00;
    step();
    check("z_busy_after", 64'(bus.busy), 64'd0);
    check("z_done_after", 64'(bus.done), 64'd0);

    // Reset two words into an 8-word stream, then a clean re-run.
    bus.req      = 2'b01;
    bus.req_addr = {32'h0, 32'h0000_0040};
    bus.req_len  = {32'd0, 32'd8};
    for (int k = 0; k < 4; k++) step();
    bus.mon_valid = 1'b1;
    bus.mon_ready = 1'b1;
    step();
    step();
    check("r_done_mid", 64'(bus.done), 64'd0);
    rst = 1'b1;
    step();
    check("r_grant", 64'(bus.grant), 64'd0);
    check("r_busy", 64'(bus.busy), 64'd0);
    check("r_done", 64'(bus.done), 64'd0);
    check("r_cfg_valid", 64'(bus.cfg_valid), 64'd0);
    rst = 1'b0;
    // Handshakes stay high through arbitration and config and must not be counted.
    txn(0, 32'h0000_0040, 8, 0, 1'b1, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_write_sched.md
Name: axis_write_sched

Overview:
- Round-robin scheduler that shares one axis_write engine between NUM_REQ stream producers.
- Arbitrates descriptor requests (start address, length) and drives the engine's config bus with the three-word sequence: ID on CONFIG_ADDR, then address, then length on CONFIG_DATA.
- Monitors the engine's input stream handshake and counts accepted words.
- Pulses per-requester done once the programmed length has been accepted, then serves the next requester.

Parameters:
NUM_REQ, 2, number of requesters (1..16)
CONFIG_ID_BASE, 1, engine ID for requester 0; requester i uses CONFIG_ID_BASE+i
CONFIG_ADDR, 23, config address selecting the engine ID register
CONFIG_DATA, 24, config address for the engine address/length words
CONFIG_AWIDTH, 5, config address width
CONFIG_DWIDTH, 32, config data width; also the request address/length width and the counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request level; held until matching done
req_addr  in  NUM_REQ*CONFIG_DWIDTH  start address; requester i occupies bits [i*CONFIG_DWIDTH +: CONFIG_DWIDTH]
req_len  in  NUM_REQ*CONFIG_DWIDTH  length in stream words, same packing
grant  out  NUM_REQ  one-hot; current owner of the engine
done  out  NUM_REQ  one-cycle pulse to the owner at completion
busy  out  1  high in every state except IDLE
cfg_addr  out  CONFIG_AWIDTH  config address to the engine
cfg_data  out  CONFIG_DWIDTH  config data to the engine
cfg_valid  out  1  config word strobe
mon_valid  in  1  engine stream input valid (observed only)
mon_ready  in  1  engine stream input ready (observed only)

Behaviour:
- Decided interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: grant=0, done=0, busy=0, cfg_addr=0, cfg_data=0, cfg_valid=0, word counter=0, state=IDLE, round-robin pointer=NUM_REQ-1 (requester 0 has first priority).
- Reset mid-operation: immediate return to the reset values. No done is issued for the aborted transfer.
- State machine:
  - IDLE -> CFG_ID when any req bit is high.
  - CFG_ID -> CFG_ADDR -> CFG_LEN.
  - CFG_LEN -> STREAM.
  - STREAM -> DONE.
  - DONE -> IDLE.
- IDLE:
  - Selects the first set req bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Latches that requester's addr and len.
  - Sets grant one-hot and updates the pointer to the selected index.
  - If the latched len is 0, goes directly to DONE: no config words are issued, and done fires 2 cycles after req is sampled.
- Config words: one per cycle, on consecutive cycles, cfg_valid high for exactly 3 cycles.
  - CFG_ID: cfg_addr=CONFIG_ADDR, cfg_data=CONFIG_ID_BASE+index.
  - CFG_ADDR: cfg_addr=CONFIG_DATA, cfg_data=latched addr.
  - CFG_LEN: cfg_addr=CONFIG_DATA, cfg_data=latched len.
  - Whenever cfg_valid is low, cfg_addr and cfg_data are 0.
- STREAM:
  - Counter increments only on a cycle where mon_valid && mon_ready.
  - When a handshake occurs with counter == len-1, the next state is DONE and the counter clears.
  - Handshakes seen outside STREAM are ignored and not counted.
- DONE (1 cycle):
  - done[index]=1; grant stays asserted this cycle.
  - Next cycle: grant=0, busy=0, state=IDLE.
- Request protocol:
  - Requester drops req in the cycle after it sees done.
  - If req is still high in IDLE, it is treated as a new request.
  - req changes while not in IDLE are ignored; a newly arriving req waits.
  - addr and len are sampled only in IDLE.
- Fairness: the owner just served has the lowest priority in the next arbitration. With all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- Arithmetic: counter and len are CONFIG_DWIDTH unsigned; len max 2^CONFIG_DWIDTH-1. len-1 is computed only for len >= 1.
- Latency: req sampled at cycle T.
  - grant/busy visible T+1.
  - Config words at T+1..T+3.
  - STREAM from T+4.
  - done one cycle after the final counted handshake.

Test Plan:
- Single requester 0, addr=4, len=8, mon_valid/mon_ready high from STREAM -> config words (23,1),(24,4),(24,8) on 3 consecutive cycles; done[0] one cycle after the 8th handshake; busy low the next cycle.
- req=2'b11 simultaneously, len=3 each -> requester 0 served first with ID 1, then requester 1 with ID 2; then, with req still high, requester 0 again.
- len=5 with mon_ready toggling 1,0,1,0 and mon_valid gaps -> done only after exactly 5 handshake cycles; non-handshake cycles not counted.
- Requester 1 len=0 -> no cfg_valid; done[1] pulses 2 cycles after req sampled.
- rst asserted after 2 of 8 words in STREAM -> next cycle all outputs 0, no done; re-request runs the full 3-word config and counts 8 words from zero.
- Requester 1 raises req while requester 0 is in STREAM -> no config activity until requester 0's done; requester 1 granted 2 cycles after done[0].
